// File: rtl/pck_socket_pkg.sv
// Shared definitions for the packet socket blocks.
//   DATA_WIDTH_DEF : default socket word width
//   MIN_DEPTH      : smallest legal FIFO depth
//   level_w()      : width of an occupancy value that can hold 0..depth
package pck_socket_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int MIN_DEPTH      = 2;

  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/pck_fifo_mem.sv
// Simple dual-port storage array for the socket FIFO.
//   clk     : write clock
//   i_we    : write enable
//   i_waddr : write address
//   i_wdata : write data
//   i_raddr : read address
//   o_rdata : asynchronous read data at i_raddr
// The array is not reset; stale contents are hidden by the owner's count.
module pck_fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]         i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pck_in_socket.sv
// Input socket: accepts a valid/ready word stream from upstream, buffers it in
// a first-word-fall-through FIFO and presents the head word to the module.
//   clk, rst      : clock, asynchronous active-low reset
//   in_data/in_valid/in_ready : upstream valid/ready stream
//   data, dv      : head word and its valid flag (fall-through)
//   full          : FIFO holds DEPTH words
//   rd_en         : module pops the head word
//   level         : registered occupancy
//   err_underflow : sticky, set when rd_en arrives while dv=0
module pck_in_socket
  import pck_socket_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_WIDTH-1:0]       in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [DATA_WIDTH-1:0]       data,
  output logic                        dv,
  output logic                        full,
  input  logic                        rd_en,
  output logic [level_w(DEPTH)-1:0]   level,
  output logic                        err_underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = level_w(DEPTH);
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  if ((DEPTH < MIN_DEPTH) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("pck_in_socket: DEPTH must be a power of two and at least 2");
  end

  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [LW-1:0]         r_count;
  logic                  r_dv;
  logic                  r_full;
  logic                  r_in_ready;
  logic                  r_err;

  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic [LW-1:0]         w_count_nx;
  logic [DATA_WIDTH-1:0] w_rd_data;

  // Acceptance uses only registered flags, so rd_en never reaches in_ready
  // combinationally: a read from a full FIFO frees space one cycle later.
  assign w_wr_acc = in_valid && r_in_ready;
  assign w_rd_acc = rd_en && r_dv;

  always_comb begin
    w_count_nx = r_count;
    unique case ({w_wr_acc, w_rd_acc})
      2'b10:   w_count_nx = r_count + LW'(1);
      2'b01:   w_count_nx = r_count - LW'(1);
      default: w_count_nx = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_dv       <= 1'b0;
      r_full     <= 1'b0;
      r_in_ready <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + AW'(1);
      if (rd_en && !r_dv) r_err <= 1'b1;
      r_count    <= w_count_nx;
      // Empty/full come from the count; pointers alone are ambiguous when equal.
      r_dv       <= (w_count_nx != '0);
      r_full     <= (w_count_nx == DEPTH_L);
      r_in_ready <= (w_count_nx != DEPTH_L);
    end
  end

  pck_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_wr_acc),
    .i_waddr (r_wr_ptr),
    .i_wdata (in_data),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_data)
  );

  assign in_ready      = r_in_ready;
  assign data          = w_rd_data;
  assign dv            = r_dv;
  assign full          = r_full;
  assign level         = r_count;
  assign err_underflow = r_err;

endmodule

// File: tb/tb_pck_in_socket.sv
module tb_pck_in_socket;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] data;
  logic       dv;
  logic       full;
  logic       rd_en;
  logic [4:0] level;
  logic       err_underflow;

  always #5 clk = ~clk;

  pck_in_socket #(.DATA_WIDTH(8), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .data          (data),
    .dv            (dv),
    .full          (full),
    .rd_en         (rd_en),
    .level         (level),
    .err_underflow (err_underflow)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] sb[$];
  int         mcount;
  logic       m_rdy;
  logic       m_err;
  int         max_lvl;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag);
    check_val({tag, "_dv"},    32'(dv),            32'(mcount != 0));
    check_val({tag, "_full"},  32'(full),          32'(mcount == DEPTH));
    check_val({tag, "_level"}, 32'(level),         32'(mcount));
    check_val({tag, "_rdy"},   32'(in_ready),      32'(m_rdy));
    check_val({tag, "_err"},   32'(err_underflow), 32'(m_err));
  endtask

  // Drive one cycle: model decides acceptance, scoreboard checks pops.
  task automatic cycle(input logic v, input logic [7:0] d, input logic r, input string tag);
    logic       wacc;
    logic       racc;
    logic [7:0] e;
    in_valid = v;
    in_data  = d;
    rd_en    = r;
    #1;
    wacc = v && m_rdy;
    racc = r && (mcount != 0);
    if (racc) begin
      e = sb.pop_front();
      check_val({tag, "_data"}, 32'(data), 32'(e));
    end
    if (r && (mcount == 0)) m_err = 1'b1;
    if (wacc) sb.push_back(d);
    @(posedge clk);
    #1;
    mcount   = mcount + int'(wacc) - int'(racc);
    m_rdy    = (mcount != DEPTH);
    in_valid = 1'b0;
    rd_en    = 1'b0;
    if (int'(level) > max_lvl) max_lvl = int'(level);
    check_flags(tag);
  endtask

  initial begin
    rst      = 1'b0;
    in_valid = 1'b0;
    rd_en    = 1'b0;
    in_data  = 8'h00;
    mcount   = 0;
    m_rdy    = 1'b0;
    m_err    = 1'b0;
    max_lvl  = 0;

    // Reset held across edges, then released mid-cycle
    repeat (3) @(posedge clk);
    #1;
    check_flags("rst");
    #2;
    rst = 1'b1;
    #1;
    check_val("rdy_before_edge", 32'(in_ready), 32'(0));
    @(posedge clk);
    #1;
    m_rdy = 1'b1;
    check_flags("release");
    repeat (3) cycle(1'b0, 8'h00, 1'b0, "idle");

    // Single word fall-through
    cycle(1'b1, 8'hA5, 1'b0, "wa5");
    check_val("data_a5", 32'(data), 32'h0000_00A5);
    cycle(1'b0, 8'h00, 1'b1, "ra5");

    // Fill to full, overflow attempt, drain in order
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b0, "fill");
    check_val("full16", 32'(full), 32'(1));
    repeat (2) cycle(1'b1, 8'hFF, 1'b0, "ovf");
    for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1, "drain");

    // Full with simultaneous read and write
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0, "fill2");
    cycle(1'b1, 8'h77, 1'b1, "fullrw");
    check_val("lvl15", 32'(level), 32'(15));
    cycle(1'b1, 8'h77, 1'b0, "acc77");
    for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1, "drain2");

    // Continuous stream across pointer wrap
    max_lvl = 0;
    for (int i = 0; i < 40; i++) cycle(1'b1, 8'(8'h40 + i), (mcount != 0), "strm");
    check_val("strm_lvl_le1", 32'(max_lvl <= 1), 32'(1));
    cycle(1'b0, 8'h00, 1'b1, "strm_tail");

    // Underflow: plain, then empty with simultaneous write
    cycle(1'b0, 8'h00, 1'b1, "uf");
    check_val("err_set", 32'(err_underflow), 32'(1));
    cycle(1'b1, 8'h3C, 1'b1, "erw");
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0, "post_uf");
    check_val("lvl5", 32'(level), 32'(5));

    // Asynchronous reset mid-stream, no clock edge in between
    #2;
    rst = 1'b0;
    #1;
    sb.delete();
    mcount = 0;
    m_rdy  = 1'b0;
    m_err  = 1'b0;
    check_flags("async_rst");
    @(posedge clk);
    #1;
    check_flags("rst_hold");
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    m_rdy = 1'b1;
    check_flags("release2");
    cycle(1'b1, 8'h5A, 1'b0, "w5a");
    cycle(1'b0, 8'h00, 1'b1, "r5a");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pck_in_socket.md
Name: pck_in_socket

Overview:
- Input socket stage feeding a processing module over the socket-to-module handshake: data, dv and full to the module, rd_en back from it.
- Accepts a valid/ready word stream from upstream (a testbench driver or the previous module's output socket).
- Buffers words in a first-word-fall-through FIFO and presents the head word to the module.
- Reports occupancy, and a sticky error when the module reads while no data is valid.

Parameters:
- DATA_WIDTH, 8, width of each data word (matches the socket interface DATA_WIDTH).
- DEPTH, 16, FIFO capacity in words; power of two, minimum 2.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (logic 0 resets).
- in_data  in  DATA_WIDTH  upstream word.
- in_valid  in  1  upstream word present.
- in_ready  out  1  socket can accept a word this cycle.
- data  out  DATA_WIDTH  head-of-FIFO word to the module.
- dv  out  1  data is valid (FIFO not empty).
- full  out  1  FIFO holds DEPTH words.
- rd_en  in  1  module pops the head word.
- level  out  $clog2(DEPTH)+1  current occupancy.
- err_underflow  out  1  sticky: rd_en seen while dv=0.

Behaviour:
- Reset (rst=0, asynchronous):
  - write pointer, read pointer and count cleared to 0.
  - dv=0, full=0, in_ready=0, level=0, err_underflow=0.
  - data is don't-care.
  - Memory contents are not reset.
- Reset release: in_ready rises at the first rising clk edge after rst goes to 1. in_ready, full, dv and level are all registered outputs.
- Write acceptance: in_valid && in_ready at an edge. in_data is stored at the write pointer and the write pointer increments modulo DEPTH.
- Read acceptance: rd_en && dv at an edge. The read pointer increments modulo DEPTH.
- rd_en while dv=0:
  - No pointer change.
  - err_underflow is set and held until reset.
- Occupancy update at each edge:
  - count_next = count + write_accepted - read_accepted.
  - level = count, registered.
  - dv_next = (count_next != 0).
  - full_next = (count_next == DEPTH).
  - in_ready_next = (count_next != DEPTH).
- Fall-through:
  - data = mem[read pointer] while dv=1 (combinational read of the storage array).
  - Latency of a word written at edge N into an empty FIFO: it appears on data with dv=1 in the cycle after edge N.
- Full, simultaneous read and write:
  - in_ready=0, so the write is not accepted.
  - The read proceeds.
  - in_ready returns to 1 in the next cycle.
  - There is no combinational path from rd_en to in_ready.
- Empty, simultaneous read and write:
  - The read is invalid: err_underflow is set.
  - The write is accepted; count becomes 1.
- Non-empty, non-full, simultaneous read and write: both are accepted and count is unchanged.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally. full/empty are decided by count, never by pointer compare.
- Reset mid-stream: all stored words are discarded immediately. Outputs take their reset values asynchronously, with no dependence on clk.

Decomposition:
- Package pck_socket_pkg holds:
  - default DATA_WIDTH;
  - a function returning the level width from DEPTH;
  - a localparam for minimum DEPTH.
- Sub-module pck_fifo_mem: simple dual-port storage array.
  - Inputs: write enable, write address, write data.
  - Output: asynchronous read data at the read address.
  - No reset.
- Pointer, count and flag logic lives in pck_in_socket.
- An elaboration-time assertion rejects DEPTH that is not a power of two or is below 2.

Test Plan:
- Reset, then idle 3 cycles:
  - dv=0, full=0, level=0, err_underflow=0;
  - in_ready=0 while rst=0;
  - in_ready=1 from the first edge after release.
- Write 0xA5 with rd_en=0: dv=1 and data=0xA5 the next cycle, level=1. Pulse rd_en: dv=0 and level=0 the next cycle.
- Write 16 words 0x00..0x0F with DEPTH=16 and no reads:
  - full=1, in_ready=0, level=16 after the 16th edge;
  - a 17th word 0xFF held on in_valid is not accepted.
  - Then read 16 times: data sequence 0x00..0x0F, then dv=0.
- Full FIFO, in_valid=1 with 0x77 and rd_en=1 in the same cycle:
  - level goes to 15 and 0x77 is not stored.
  - The next cycle in_ready=1; 0x77 is accepted and becomes the last word read out.
- Continuous stream across wrap: 40 words with in_valid=1 and rd_en=dv every cycle.
  - Output order equals input order.
  - level never exceeds 1.
  - err_underflow stays 0.
- rd_en=1 while empty: err_underflow=1 and stays 1 through later valid traffic. Assert rst=0 mid-stream with level=5: all outputs return to reset values with no clk edge required.
